mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle MIPS control unit. It sequences the shared datapath (one ALU, one unified memory port, and the 2:1 register-destination, memory-to-register, address and ALU-operand muxes) over several cycles per instruction. It sits between the instruction register/ALU flags and every datapath select/enable, and adds a memory ready handshake with timeout.

## Interface
- MEM_TIMEOUT, 255: max cycles a memory state waits for mem_ready before trapping; 0 disables the timeout.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag, valid in BEQ_EX.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  address mux select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  register-destination mux select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back mux select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- illegal_op  out  1  sticky: unsupported opcode or funct.
- bus_err  out  1  sticky: memory timeout.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, ALU_WB, BEQ_EX, ADDI_EX, ADDI_WB, JUMP_EX, TRAP.
- Any output not listed for a state is 0.
- IDLE: all outputs 0. Always goes to FETCH next.
- FETCH: mem_read=1, iord=0, alu_src_b=01, alu_ctrl=add, pc_src=00. ir_write and pc_write equal mem_ready.
  - Advances to DECODE when mem_ready=1; otherwise holds.
- DECODE: alu_src_b=11, alu_ctrl=add (branch target precompute). Next state by opcode:
  - 100011 or 101011 -> MEMADR.
  - 000000 with a legal funct -> RTYPE_EX. Legal funct: 100000, 100010, 100100, 100101, 101010.
  - 000100 -> BEQ_EX.
  - 001000 -> ADDI_EX.
  - 000010 -> JUMP_EX.
  - Anything else, including an illegal funct -> TRAP, with illegal_op set.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Goes to MEMWB on mem_ready.
- MEMWB: mem_to_reg=1, reg_write=1, reg_dst=0.
- MEMWR: iord=1, mem_write=1. Goes to FETCH on mem_ready.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_ctrl from funct. Goes to ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1.
- BEQ_EX: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01.
- ADDI_EX: alu_src_a=1, alu_src_b=10, add. Goes to ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1.
- JUMP_EX: pc_src=10, pc_write=1.
- MEMWB, ALU_WB, ADDI_WB, BEQ_EX and JUMP_EX all return to FETCH.
- TRAP: all strobes 0. Stays in TRAP until reset.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle those states hold with mem_ready=0.
  - When it reaches MEM_TIMEOUT: go to TRAP and set bus_err.
  - mem_ready arriving in that same cycle wins; no error.

## Timing
- Reset values: state=IDLE, all outputs 0, illegal_op=0, bus_err=0, wait counter=0.
- Reset is asynchronous; deassertion is registered, so the first rising edge after release enters FETCH.
- Outputs are decoded from the registered state. Only ir_write, pc_write and pc_en are Mealy, combinational on mem_ready/zero.
- Cycles per instruction with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each memory wait cycle adds 1.
- Reset mid-instruction aborts immediately with no partial write. Outputs drop to 0 asynchronously.

## Structure
- Shared package mips_ctrl_pkg holds:
  - the state enum;
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct codes;
  - alu_ctrl codes;
  - alu_src_b and pc_src encodings.
- Sub-module mips_alu_decoder: combinational (alu_op[1:0], funct) -> alu_ctrl, funct_legal.
  - alu_op: 00 add, 01 sub, 10 funct.
- The FSM, wait counter and sticky flags live in the top module.

## Test plan
- Reset then lw (opcode 100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 with mem_to_reg=1, reg_dst=0 in cycle 5.
- R-type, funct 100010 -> alu_ctrl=110 in RTYPE_EX. ALU_WB has reg_dst=1, reg_write=1. Back to FETCH after 4 cycles.
- beq twice:
  - zero=1 -> pc_en=1 with pc_src=01 in BEQ_EX.
  - zero=0 -> pc_en=0.
  - Both take 3 cycles.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles, then FETCH. bus_err stays 0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 wait cycles, bus_err=1. It holds until rst_n pulses low, then returns to IDLE with all outputs 0.
- Opcode 111111 -> TRAP from DECODE, illegal_op=1.
- Reset asserted during MEMRD -> mem_read drops in the same cycle; FETCH follows release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes and datapath select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_ALU_WB, S_BEQ_EX, S_ADDI_EX, S_ADDI_WB, S_JUMP_EX, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOP_NONE yields alu_ctrl=000 in states that do not use the ALU
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU control decode: add/sub forced by the FSM, otherwise taken from funct.
// funct_legal is independent of alu_op so DECODE can vet R-type instructions.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_legal
);

    logic [2:0] funct_ctrl;

    always_comb begin
        funct_legal = 1'b1;
        funct_ctrl  = ALU_ADD;
        case (funct)
            F_ADD:   funct_ctrl = ALU_ADD;
            F_SUB:   funct_ctrl = ALU_SUB;
            F_AND:   funct_ctrl = ALU_AND;
            F_OR:    funct_ctrl = ALU_OR;
            F_SLT:   funct_ctrl = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALUOP_ADD:   alu_ctrl = ALU_ADD;
            ALUOP_SUB:   alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: alu_ctrl = funct_ctrl;
            default:     alu_ctrl = 3'b000;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-ready handshake, wait timeout and
// sticky illegal-instruction / bus-error flags.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       bus_err
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    alu_op;
    logic          pc_write, branch, mem_wait, timeout, funct_legal;
    logic          set_ill, set_berr;

    mips_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_ctrl    (alu_ctrl),
        .funct_legal (funct_legal)
    );

    // Trap on the edge where the counter would reach MEM_TIMEOUT; ready wins
    assign timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                     (wait_cnt == CW'(MEM_TIMEOUT - 1));
    assign pc_en   = pc_write | (branch & zero);

    always_comb begin
        state_nx   = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_NONE;
        pc_src     = PC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        mem_wait   = 1'b0;
        set_ill    = 1'b0;
        case (state)
            S_IDLE: state_nx = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                mem_wait  = 1'b1;
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE: begin
                        state_nx = funct_legal ? S_RTYPE_EX : S_TRAP;
                        set_ill  = !funct_legal;
                    end
                    OP_BEQ:  state_nx = S_BEQ_EX;
                    OP_ADDI: state_nx = S_ADDI_EX;
                    OP_J:    state_nx = S_JUMP_EX;
                    default: begin
                        state_nx = S_TRAP;
                        set_ill  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_nx  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                mem_wait = 1'b1;
                if (mem_ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_nx   = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                mem_wait  = 1'b1;
                if (mem_ready) state_nx = S_FETCH;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_nx  = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_nx  = S_FETCH;
            end
            S_BEQ_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                pc_src    = PC_ALUOUT;
                state_nx  = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                state_nx  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_nx  = S_FETCH;
            end
            S_JUMP_EX: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_TRAP;
        endcase
        set_berr = mem_wait && timeout;
        if (set_berr) state_nx = S_TRAP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state <= state_nx;
            // Any state change is an entry, so the count restarts per access
            if (state_nx != state)
                wait_cnt <= '0;
            else if (mem_wait && !mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
            if (set_ill)  illegal_op <= 1'b1;
            if (set_berr) bus_err    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-cycle control words from an instruction-level model,
// run on a default-timeout instance and a MEM_TIMEOUT=4 instance in parallel.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
        logic       bus_err;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic       pc_en, illegal_op, bus_err;
    logic       mem_read_4, mem_write_4, iord_4, ir_write_4, reg_dst_4, mem_to_reg_4, reg_write_4, alu_src_a_4;
    logic [1:0] alu_src_b_4, pc_src_4;
    logic [2:0] alu_ctrl_4;
    logic       pc_en_4, illegal_op_4, bus_err_4;

    ctl_t act, act4;
    int   n_chk = 0;
    int   n_err = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .pc_src(pc_src), .pc_en(pc_en),
        .illegal_op(illegal_op), .bus_err(bus_err)
    );

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read_4), .mem_write(mem_write_4), .iord(iord_4),
        .ir_write(ir_write_4), .reg_dst(reg_dst_4), .mem_to_reg(mem_to_reg_4),
        .reg_write(reg_write_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
        .alu_ctrl(alu_ctrl_4), .pc_src(pc_src_4), .pc_en(pc_en_4),
        .illegal_op(illegal_op_4), .bus_err(bus_err_4)
    );

    assign act  = {mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, illegal_op, bus_err};
    assign act4 = {mem_read_4, mem_write_4, iord_4, ir_write_4, reg_dst_4, mem_to_reg_4,
                   reg_write_4, alu_src_a_4, alu_src_b_4, alu_ctrl_4, pc_src_4, pc_en_4,
                   illegal_op_4, bus_err_4};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Expected control words for each step of an instruction's life
    function automatic ctl_t w_fetch(input logic r);
        ctl_t c = '0;
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010;
        c.ir_write = r; c.pc_en = r;
        return c;
    endfunction
    function automatic ctl_t w_decode();
        ctl_t c = '0;
        c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010;
        return c;
    endfunction
    function automatic ctl_t w_addr_imm();
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010;
        return c;
    endfunction
    function automatic ctl_t w_mem(input logic wr);
        ctl_t c = '0;
        c.iord = 1'b1; c.mem_read = !wr; c.mem_write = wr;
        return c;
    endfunction
    function automatic ctl_t w_wb(input logic dst, input logic m2r);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = dst; c.mem_to_reg = m2r;
        return c;
    endfunction
    function automatic ctl_t w_rex(input logic [5:0] f);
        ctl_t c = '0;
        c.alu_src_a = 1'b1;
        case (f)
            6'b100000: c.alu_ctrl = 3'b010;
            6'b100010: c.alu_ctrl = 3'b110;
            6'b100100: c.alu_ctrl = 3'b000;
            6'b100101: c.alu_ctrl = 3'b001;
            default:   c.alu_ctrl = 3'b111;
        endcase
        return c;
    endfunction
    function automatic ctl_t w_beq(input logic z);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.pc_en = z;
        return c;
    endfunction
    function automatic ctl_t w_jump();
        ctl_t c = '0;
        c.pc_src = 2'b10; c.pc_en = 1'b1;
        return c;
    endfunction
    function automatic ctl_t w_trap(input logic ill, input logic berr);
        ctl_t c = '0;
        c.illegal_op = ill; c.bus_err = berr;
        return c;
    endfunction

    task automatic cyc2(input string tag, input logic r, input logic z, input ctl_t e, input ctl_t e4);
        @(negedge clk);
        mem_ready = r;
        zero = z;
        #1;
        chk(tag, {14'b0, act}, {14'b0, e});
        chk({tag, "_t4"}, {14'b0, act4}, {14'b0, e4});
    endtask

    task automatic cyc(input string tag, input logic r, input logic z, input ctl_t e);
        cyc2(tag, r, z, e, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst", {14'b0, act}, 32'd0);
        chk("rst_t4", {14'b0, act4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle", {14'b0, act}, 32'd0);
        chk("idle_t4", {14'b0, act4}, 32'd0);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // One instruction: wf fetch wait cycles, wm data-memory wait cycles
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < wf; i++) cyc("fetch_wait", 1'b0, rb(), w_fetch(1'b0));
        cyc("fetch", 1'b1, rb(), w_fetch(1'b1));
        cyc("decode", rb(), rb(), w_decode());
        case (op)
            LW: begin
                cyc("lw_adr", rb(), rb(), w_addr_imm());
                for (int i = 0; i < wm; i++) cyc("lw_rd_wait", 1'b0, rb(), w_mem(1'b0));
                cyc("lw_rd", 1'b1, rb(), w_mem(1'b0));
                cyc("lw_wb", rb(), rb(), w_wb(1'b0, 1'b1));
            end
            SW: begin
                cyc("sw_adr", rb(), rb(), w_addr_imm());
                for (int i = 0; i < wm; i++) cyc("sw_wr_wait", 1'b0, rb(), w_mem(1'b1));
                cyc("sw_wr", 1'b1, rb(), w_mem(1'b1));
            end
            RT: begin
                cyc("r_ex", rb(), rb(), w_rex(fn));
                cyc("r_wb", rb(), rb(), w_wb(1'b1, 1'b0));
            end
            BEQ:  cyc("beq", rb(), z, w_beq(z));
            ADDI: begin
                cyc("addi_ex", rb(), rb(), w_addr_imm());
                cyc("addi_wb", rb(), rb(), w_wb(1'b0, 1'b0));
            end
            default: cyc("jump", rb(), rb(), w_jump());
        endcase
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        ops = '{LW, SW, RT, BEQ, ADDI, JMP};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        do_reset();
        run_instr(LW, 6'h00, 1'b0, 0, 0);
        run_instr(RT, 6'b100010, 1'b0, 0, 0);
        run_instr(BEQ, 6'h15, 1'b1, 0, 0);
        run_instr(BEQ, 6'h2a, 1'b0, 0, 0);
        run_instr(SW, 6'h00, 1'b0, 0, 3);
        run_instr(JMP, 6'h3f, 1'b0, 0, 0);
        run_instr(ADDI, 6'h00, 1'b0, 0, 0);

        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(5, 0)], fns[$urandom_range(4, 0)], rb(),
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));

        // illegal opcode
        opcode = 6'b111111;
        cyc("ill_fetch", 1'b1, 1'b0, w_fetch(1'b1));
        cyc("ill_decode", 1'b1, 1'b0, w_decode());
        for (int i = 0; i < 3; i++) cyc("ill_trap", rb(), rb(), w_trap(1'b1, 1'b0));
        do_reset();

        // R-type with an illegal funct
        opcode = RT;
        funct  = 6'b000001;
        cyc("ilf_fetch", 1'b1, 1'b0, w_fetch(1'b1));
        cyc("ilf_decode", 1'b1, 1'b0, w_decode());
        cyc("ilf_trap", 1'b1, 1'b1, w_trap(1'b1, 1'b0));
        do_reset();
        run_instr(RT, 6'b101010, 1'b0, 1, 0);

        // fetch timeout: only the MEM_TIMEOUT=4 instance traps
        do_reset();
        for (int i = 0; i < 4; i++) cyc("to_wait", 1'b0, rb(), w_fetch(1'b0));
        cyc2("to_trap", 1'b0, 1'b0, w_fetch(1'b0), w_trap(1'b0, 1'b1));
        cyc2("to_hold", 1'b1, 1'b0, w_fetch(1'b1), w_trap(1'b0, 1'b1));
        do_reset();
        run_instr(SW, 6'h00, 1'b0, 3, 3);

        // reset asserted mid-MEMRD
        opcode = LW;
        cyc("ab_fetch", 1'b1, 1'b0, w_fetch(1'b1));
        cyc("ab_decode", 1'b0, 1'b0, w_decode());
        cyc("ab_adr", 1'b0, 1'b0, w_addr_imm());
        cyc("ab_rd", 1'b0, 1'b0, w_mem(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_rst", {14'b0, act}, 32'd0);
        chk("ab_rst_t4", {14'b0, act4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ab_idle", {14'b0, act}, 32'd0);
        cyc("ab_refetch", 1'b1, 1'b0, w_fetch(1'b1));
        cyc("ab_decode2", 1'b1, 1'b0, w_decode());

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
